// File: rtl/mvu_weight_streamer.sv
// On-chip weight source: holds the NF x SF tile matrix and replays it forever as an
// AXI-Stream, with a 2-entry output buffer to absorb back-pressure at full rate.
module mvu_weight_streamer #(
    parameter  int MW           = 120,
    parameter  int MH           = 40,
    parameter  int PE           = 10,
    parameter  int SIMD         = 20,
    parameter  int WEIGHT_WIDTH = 4,
    localparam int NF           = MH / PE,
    localparam int SF           = MW / SIMD,
    localparam int DEPTH        = NF * SF,
    localparam int TILE_W       = PE * SIMD * WEIGHT_WIDTH,
    localparam int STREAM_W     = ((TILE_W + 7) / 8) * 8,
    localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [TILE_W-1:0]   cfg_wdata,
    output logic [STREAM_W-1:0] m_axis_weights_tdata,
    output logic                m_axis_weights_tvalid,
    input  logic                m_axis_weights_tready
);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [TILE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [1:0]        occ;
    logic              vld_p1;
    logic [TILE_W-1:0] rd_data_p1;
    logic [TILE_W-1:0] head_p2;
    logic [TILE_W-1:0] tail_p2;
    logic              pop;
    logic              issue;
    logic              wr_ok;

    assign pop   = (occ != 2'd0) && m_axis_weights_tready;
    // Reserve a FIFO slot for every read in flight so the buffer can never overflow.
    assign issue = ({1'b0, occ} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop});
    assign wr_ok = cfg_we && ({1'b0, cfg_addr} < DEPTH_C);

    // Stage p1: registered memory read; a same-edge write is seen only by later reads.
    always_ff @(posedge ap_clk) begin
        if (wr_ok) begin
            mem[cfg_addr] <= cfg_wdata;
        end
        if (issue) begin
            rd_data_p1 <= mem[rd_ptr];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rd_ptr <= '0;
            occ    <= 2'd0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            end
            occ <= occ + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

    // Stage p2: two-entry output buffer, head drives the stream.
    always_ff @(posedge ap_clk) begin
        if (pop) begin
            head_p2 <= (occ == 2'd2) ? tail_p2 : rd_data_p1;
            if (vld_p1) begin
                tail_p2 <= rd_data_p1;
            end
        end else if (vld_p1) begin
            if (occ == 2'd0) begin
                head_p2 <= rd_data_p1;
            end else begin
                tail_p2 <= rd_data_p1;
            end
        end
    end

    assign m_axis_weights_tvalid = (occ != 2'd0);

    // Buffer data is never reset, so mask it while idle to present zeros.
    always_comb begin
        m_axis_weights_tdata               = '0;
        m_axis_weights_tdata[TILE_W-1:0]   = m_axis_weights_tvalid ? head_p2 : '0;
    end

endmodule
